// File: rtl/cpu_pkg.sv
// Shared fetch-control definitions: PCSrc encoding, PC sequencer states, trap cause codes.
// Also imported by the setPrePCSrc logic in the branch-resolution stage.
package cpu_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_EXCEPT = 2'b10,
        PCSRC_JALR   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        TRAP_SAVE = 2'd2,
        TRAP_JUMP = 2'd3
    } seq_state_e;

    localparam logic [3:0] CAUSE_INSN_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSN    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT      = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M         = 4'd11;

    typedef struct packed {
        logic        misaligned;
        logic [31:0] target;
    } redir_t;

endpackage

// File: rtl/pc_seq_ctrl.sv
// Fetch PC sequencer: sequential fetch, branch/jalr/mret redirects with a one-cycle
// flush, and a two-cycle trap sequence that writes mepc/mcause and jumps to mtvec.
module pc_seq_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [3:0]  MISALIGN_CAUSE = 4'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_PCSrc,
    input  logic        i_stall,
    input  logic        i_mret,
    input  logic [31:0] i_branchTarget,
    input  logic [31:0] i_jalrTarget,
    input  logic [31:0] i_exPC,
    input  logic [3:0]  i_exCause,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic [31:0] o_pc,
    output logic        o_flush,
    output logic        o_busy,
    output logic        o_csrWe,
    output logic [31:0] o_mepcWr,
    output logic [3:0]  o_mcauseWr
);

    seq_state_e  r_state;
    seq_state_e  w_state_nx;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nx;
    logic        r_flush;
    logic        w_flush_nx;
    logic [31:0] r_mepc;
    logic [31:0] w_mepc_nx;
    logic [3:0]  r_mcause;
    logic [3:0]  w_mcause_nx;
    pcsrc_e      w_src;
    redir_t      w_redir;

    // Only bit 1 is checked: jalr already clears bit 0, and branch offsets are even.
    function automatic redir_t f_sel_target(input pcsrc_e src,
                                            input logic [31:0] br,
                                            input logic [31:0] jalr);
        redir_t r;
        r.target     = (src == PCSRC_JALR) ? (jalr & ~32'h1) : br;
        r.misaligned = r.target[1];
        return r;
    endfunction

    assign w_src   = pcsrc_e'(i_PCSrc);
    assign w_redir = f_sel_target(w_src, i_branchTarget, i_jalrTarget);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_flush  <= 1'b0;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_flush  <= w_flush_nx;
            r_mepc   <= w_mepc_nx;
            r_mcause <= w_mcause_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_flush_nx  = 1'b0;
        w_mepc_nx   = r_mepc;
        w_mcause_nx = r_mcause;
        case (r_state)
            RUN: begin
                if (w_src == PCSRC_EXCEPT) begin
                    w_mepc_nx   = i_exPC;
                    w_mcause_nx = i_exCause;
                    w_flush_nx  = 1'b1;
                    w_state_nx  = TRAP_SAVE;
                end else if (i_mret) begin
                    w_pc_nx    = i_mepc & ~32'h3;
                    w_flush_nx = 1'b1;
                    w_state_nx = FLUSH;
                end else if (w_src == PCSRC_JALR || w_src == PCSRC_BRANCH) begin
                    w_flush_nx = 1'b1;
                    if (w_redir.misaligned) begin
                        w_mepc_nx   = i_exPC;
                        w_mcause_nx = MISALIGN_CAUSE;
                        w_state_nx  = TRAP_SAVE;
                    end else begin
                        w_pc_nx    = w_redir.target;
                        w_state_nx = FLUSH;
                    end
                end else if (!i_stall) begin
                    w_pc_nx = r_pc + 32'd4;
                end
            end
            FLUSH: begin
                if (!i_stall) begin
                    w_pc_nx = r_pc + 32'd4;
                end
                w_state_nx = RUN;
            end
            TRAP_SAVE: begin
                w_state_nx = TRAP_JUMP;
            end
            TRAP_JUMP: begin
                w_pc_nx    = i_mtvec & ~32'h3;
                w_flush_nx = 1'b1;
                w_state_nx = FLUSH;
            end
            default: begin
                w_state_nx = RUN;
            end
        endcase
    end

    assign o_pc       = r_pc;
    assign o_flush    = r_flush;
    assign o_busy     = (r_state == TRAP_SAVE) || (r_state == TRAP_JUMP);
    assign o_csrWe    = (r_state == TRAP_SAVE);
    assign o_mepcWr   = r_mepc;
    assign o_mcauseWr = r_mcause;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed vector table, async-reset-mid-trap
// sequence, then randomized traffic against a cycle-level reference model.
module tb_pc_seq_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic [1:0]  i_PCSrc;
    logic        i_stall;
    logic        i_mret;
    logic [31:0] i_branchTarget;
    logic [31:0] i_jalrTarget;
    logic [31:0] i_exPC;
    logic [3:0]  i_exCause;
    logic [31:0] i_mtvec;
    logic [31:0] i_mepc;
    logic [31:0] o_pc;
    logic        o_flush;
    logic        o_busy;
    logic        o_csrWe;
    logic [31:0] o_mepcWr;
    logic [3:0]  o_mcauseWr;

    int n_checks;
    int n_errors;

    pc_seq_ctrl #(
        .RESET_PC       (32'h0000_0000),
        .MISALIGN_CAUSE (4'd0)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_PCSrc        (i_PCSrc),
        .i_stall        (i_stall),
        .i_mret         (i_mret),
        .i_branchTarget (i_branchTarget),
        .i_jalrTarget   (i_jalrTarget),
        .i_exPC         (i_exPC),
        .i_exCause      (i_exCause),
        .i_mtvec        (i_mtvec),
        .i_mepc         (i_mepc),
        .o_pc           (o_pc),
        .o_flush        (o_flush),
        .o_busy         (o_busy),
        .o_csrWe        (o_csrWe),
        .o_mepcWr       (o_mepcWr),
        .o_mcauseWr     (o_mcauseWr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  src;
        logic        stall;
        logic        mret;
        logic [31:0] br;
        logic [31:0] jalr;
        logic [31:0] expc;
        logic [3:0]  cause;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_busy;
        logic        e_we;
        logic [31:0] e_mepc;
        logic [3:0]  e_cause;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t V(input logic [1:0] src, input logic stall, input logic mret,
                               input logic [31:0] br, input logic [31:0] jalr,
                               input logic [31:0] expc, input logic [3:0] cause,
                               input logic [31:0] mtvec, input logic [31:0] mepc,
                               input logic [31:0] e_pc, input logic e_flush,
                               input logic e_busy, input logic e_we,
                               input logic [31:0] e_mepc, input logic [3:0] e_cause);
        vec_t v;
        v.src = src; v.stall = stall; v.mret = mret; v.br = br; v.jalr = jalr;
        v.expc = expc; v.cause = cause; v.mtvec = mtvec; v.mepc = mepc;
        v.e_pc = e_pc; v.e_flush = e_flush; v.e_busy = e_busy; v.e_we = e_we;
        v.e_mepc = e_mepc; v.e_cause = e_cause;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic fl,
                           input logic busy, input logic we, input logic [31:0] mepc,
                           input logic [3:0] cause);
        chk({tag, ".pc"},     o_pc,              pc);
        chk({tag, ".flush"},  {31'd0, o_flush},  {31'd0, fl});
        chk({tag, ".busy"},   {31'd0, o_busy},   {31'd0, busy});
        chk({tag, ".csrWe"},  {31'd0, o_csrWe},  {31'd0, we});
        chk({tag, ".mepcWr"}, o_mepcWr,          mepc);
        chk({tag, ".mcause"}, {28'd0, o_mcauseWr}, {28'd0, cause});
    endtask

    // Reference model: tracks remaining trap cycles and a one-cycle "ignore redirects"
    // window, computing the outputs expected after the next rising edge.
    logic [31:0] m_pc, m_mepc;
    logic [3:0]  m_cause;
    int          m_trap_left;
    bit          m_quiet;
    bit          m_flush;

    function automatic void m_reset();
        m_pc = 32'h0; m_mepc = 32'h0; m_cause = 4'h0;
        m_trap_left = 0; m_quiet = 0; m_flush = 0;
    endfunction

    function automatic void m_trap(input logic [31:0] pc, input logic [3:0] c);
        m_mepc = pc; m_cause = c; m_trap_left = 2; m_flush = 1;
    endfunction

    function automatic void m_step();
        logic [31:0] t;
        m_flush = 0;
        if (m_trap_left == 2) begin
            m_trap_left = 1;
        end else if (m_trap_left == 1) begin
            m_pc = i_mtvec & ~32'h3;
            m_trap_left = 0;
            m_quiet = 1;
            m_flush = 1;
        end else if (m_quiet) begin
            m_quiet = 0;
            if (!i_stall) m_pc = m_pc + 32'd4;
        end else if (i_PCSrc == 2'd2) begin
            m_trap(i_exPC, i_exCause);
        end else if (i_mret) begin
            m_pc = i_mepc & ~32'h3; m_quiet = 1; m_flush = 1;
        end else if (i_PCSrc == 2'd3 || i_PCSrc == 2'd1) begin
            t = (i_PCSrc == 2'd3) ? (i_jalrTarget & ~32'h1) : i_branchTarget;
            if (((t >> 1) & 32'h1) != 0) m_trap(i_exPC, 4'd0);
            else begin m_pc = t; m_quiet = 1; m_flush = 1; end
        end else if (!i_stall) begin
            m_pc = m_pc + 32'd4;
        end
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_PCSrc = 2'd0; i_stall = 0; i_mret = 0; i_branchTarget = '0; i_jalrTarget = '0;
        i_exPC = '0; i_exCause = '0; i_mtvec = '0; i_mepc = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        i_rst = 1'b1;

        vecs[0]  = V(0,0,0, 0,0,0,0,0,0,                32'h0,1'b0,0,0, 32'h0,4'h0);
        vecs[0].e_pc = 32'h4;
        vecs[1]  = V(0,0,0, 0,0,0,0,0,0,                32'h8,0,0,0, 0,0);
        vecs[2]  = V(0,0,0, 0,0,0,0,0,0,                32'hC,0,0,0, 0,0);
        vecs[3]  = V(0,1,0, 0,0,0,0,0,0,                32'hC,0,0,0, 0,0);
        vecs[4]  = V(1,0,0, 32'h20,0,0,0,0,0,           32'h20,1,0,0, 0,0);
        vecs[5]  = V(1,1,0, 32'h500,0,0,0,0,0,          32'h20,0,0,0, 0,0);
        vecs[6]  = V(1,1,0, 32'h100,0,0,0,0,0,          32'h100,1,0,0, 0,0);
        vecs[7]  = V(0,0,0, 0,0,0,0,0,0,                32'h104,0,0,0, 0,0);
        vecs[8]  = V(3,0,0, 0,32'h203,32'h44,4'd7,0,0,  32'h104,1,1,1, 32'h44,0);
        vecs[9]  = V(1,1,1, 32'h300,0,0,0,32'h1003,0,   32'h104,0,1,0, 32'h44,0);
        vecs[10] = V(2,0,0, 0,0,32'h9,4'd9,32'h1003,0,  32'h1000,1,0,0, 32'h44,0);
        vecs[11] = V(3,0,0, 0,32'h999,0,0,0,0,          32'h1004,0,0,0, 32'h44,0);
        vecs[12] = V(2,0,1, 0,0,32'h1004,4'hB,0,32'h80, 32'h1004,1,1,1, 32'h1004,4'hB);
        vecs[13] = V(0,0,0, 0,0,0,0,32'h2000,0,         32'h1004,0,1,0, 32'h1004,4'hB);
        vecs[14] = V(0,0,0, 0,0,0,0,32'h2000,0,         32'h2000,1,0,0, 32'h1004,4'hB);
        vecs[15] = V(0,0,0, 0,0,0,0,0,0,                32'h2004,0,0,0, 32'h1004,4'hB);
        vecs[16] = V(0,0,1, 0,0,0,0,0,32'h3007,         32'h3004,1,0,0, 32'h1004,4'hB);
        vecs[17] = V(0,0,0, 0,0,0,0,0,0,                32'h3008,0,0,0, 32'h1004,4'hB);
        vecs[18] = V(3,0,0, 0,32'h4005,0,0,0,0,         32'h4004,1,0,0, 32'h1004,4'hB);
        vecs[19] = V(0,0,0, 0,0,0,0,0,0,                32'h4008,0,0,0, 32'h1004,4'hB);
        vecs[20] = V(1,0,0, 32'hFFFF_FFFC,0,0,0,0,0,    32'hFFFF_FFFC,1,0,0, 32'h1004,4'hB);
        vecs[21] = V(0,1,0, 0,0,0,0,0,0,                32'hFFFF_FFFC,0,0,0, 32'h1004,4'hB);
        vecs[22] = V(0,0,0, 0,0,0,0,0,0,                32'h0,0,0,0, 32'h1004,4'hB);

        tick();
        chk_all("reset", 32'h0, 0, 0, 0, 32'h0, 4'h0);
        i_rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            i_PCSrc = vecs[i].src; i_stall = vecs[i].stall; i_mret = vecs[i].mret;
            i_branchTarget = vecs[i].br; i_jalrTarget = vecs[i].jalr;
            i_exPC = vecs[i].expc; i_exCause = vecs[i].cause;
            i_mtvec = vecs[i].mtvec; i_mepc = vecs[i].mepc;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_flush, vecs[i].e_busy,
                    vecs[i].e_we, vecs[i].e_mepc, vecs[i].e_cause);
        end

        // Async reset landing in TRAP_SAVE must kill the CSR write immediately.
        idle_inputs();
        i_PCSrc = 2'd2; i_exPC = 32'h77; i_exCause = 4'd5;
        tick();
        chk_all("rst_pre", 32'h0, 1, 1, 1, 32'h77, 4'd5);
        idle_inputs();
        #2 i_rst = 1'b1;
        #1;
        chk_all("rst_mid", 32'h0, 0, 0, 0, 32'h0, 4'h0);
        tick();
        i_rst = 1'b0;
        tick();
        chk_all("rst_resume", 32'h4, 0, 0, 0, 32'h0, 4'h0);

        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        m_reset();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                i_rst = 1'b1;
                #1;
                m_reset();
                chk_all($sformatf("rnd%0d_rst", n), m_pc, m_flush, 1'b0, 1'b0, m_mepc, m_cause);
                tick();
                i_rst = 1'b0;
            end else begin
                int r;
                logic [31:0] t;
                r = $urandom_range(0, 9);
                i_PCSrc = (r < 5 || r == 9) ? 2'd0 : (r < 7) ? 2'd1 : (r == 7) ? 2'd3 : 2'd2;
                i_stall = ($urandom_range(0, 3) == 0);
                i_mret  = ($urandom_range(0, 7) == 0);
                t = $urandom(); if ($urandom_range(0, 3) != 0) t[1] = 1'b0;
                i_branchTarget = t;
                t = $urandom(); if ($urandom_range(0, 3) != 0) t[1] = 1'b0;
                i_jalrTarget = t;
                i_exPC = $urandom(); i_exCause = 4'($urandom());
                i_mtvec = $urandom(); i_mepc = $urandom();
                m_step();
                tick();
                chk_all($sformatf("rnd%0d", n), m_pc, m_flush, (m_trap_left > 0),
                        (m_trap_left == 2), m_mepc, m_cause);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter MISALIGN_CAUSE, default 4'd0, the mcause code for a misaligned redirect target.
REQ-003 SHALL have port i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_PCSrc  in  2  from branch resolution: 00 PC+4, 01 taken branch, 10 exception, 11 jalr.
REQ-006 SHALL have port i_stall  in  1  hazard stall from decode.
REQ-007 SHALL have port i_mret  in  1  mret resolved in EX.
REQ-008 SHALL have ports i_branchTarget and i_jalrTarget  in  32 each  redirect targets.
REQ-009 SHALL have ports i_exPC (in 32, PC of the EX instruction) and i_exCause (in 4, exception cause).
REQ-010 SHALL have ports i_mtvec and i_mepc  in  32 each  CSR values.
REQ-011 SHALL have port o_pc  out  32  fetch PC.
REQ-012 SHALL have port o_flush  out  1  kill IF/ID and ID/EX contents.
REQ-013 SHALL have port o_busy  out  1  high while a trap sequence is in progress.
REQ-014 SHALL have ports o_csrWe (out 1), o_mepcWr (out 32) and o_mcauseWr (out 4), the trap CSR write.

Function
REQ-015 SHALL implement FSM states RUN, FLUSH, TRAP_SAVE and TRAP_JUMP.
REQ-016 RUN, no redirect: if !i_stall, o_pc <= o_pc+4 (mod 2^32, wrapping 32'hFFFF_FFFC -> 0); if i_stall, o_pc holds.
REQ-017 RUN redirect priority SHALL be: exception (10) > i_mret > jalr (11) > branch (01); a redirect overrides i_stall.
REQ-018 Branch: o_pc <= i_branchTarget; jalr: o_pc <= i_jalrTarget & ~32'h1; mret: o_pc <= i_mepc & ~32'h3; each SHALL go to FLUSH.
REQ-019 If the computed branch/jalr target has bit 1 set, SHALL not redirect; SHALL instead take an exception with cause MISALIGN_CAUSE and mepc i_exPC.
REQ-020 Exception (10 or misaligned): SHALL latch i_exPC and the cause, hold o_pc, and go to TRAP_SAVE.
REQ-021 o_flush SHALL be registered and high exactly in the cycle after any redirect or exception decision, i.e. in the first FLUSH or TRAP_SAVE cycle.
REQ-022 FLUSH lasts 1 cycle: SHALL ignore i_PCSrc and i_mret, advance o_pc by 4 unless i_stall, then return to RUN.
REQ-023 TRAP_SAVE lasts 1 cycle: o_csrWe=1, o_mepcWr=latched PC, o_mcauseWr=latched cause; next state TRAP_JUMP.
REQ-024 TRAP_JUMP lasts 1 cycle: o_pc <= i_mtvec & ~32'h3; SHALL assert o_flush in the following cycle and go to FLUSH, then RUN.
REQ-025 o_busy SHALL be high in TRAP_SAVE and TRAP_JUMP; all inputs except i_mtvec SHALL be ignored there.
REQ-026 o_csrWe SHALL be 0 outside TRAP_SAVE, with o_mepcWr and o_mcauseWr holding their last latched values.
REQ-027 Redirect latency SHALL be 1 cycle (o_pc equals the target the cycle after the decision); trap latency SHALL be 3 cycles to mtvec.

Reset
REQ-028 On i_rst SHALL set: o_pc=RESET_PC, state RUN, o_flush=0, o_busy=0, o_csrWe=0, o_mepcWr=0, o_mcauseWr=0.
REQ-029 Reset asserted mid-trap or mid-FLUSH SHALL abort the sequence immediately, with no CSR write completing after the reset edge.

Structure
REQ-030 SHALL define the PCSrc encoding, the FSM state enum and the cause codes in shared package cpu_pkg, shared with setPrePCSrc users.
REQ-031 SHALL use no sub-module; the target select/align check SHALL be a local function.

Verification
REQ-032 Reset, then 3 unstalled cycles -> o_pc 0, 4, 8, 12.
REQ-033 At o_pc=0x20, i_PCSrc=01, target 0x100, i_stall=1 -> next o_pc=0x100, o_flush=1 for one cycle, then 0x104.
REQ-034 i_PCSrc=11, i_jalrTarget=0x203 -> o_pc=0x202? No: bit1 set -> trap; o_csrWe=1 with o_mepcWr=i_exPC, o_mcauseWr=0; o_pc=i_mtvec&~3 after 3 cycles.
REQ-035 i_PCSrc=10 and i_mret=1 in the same cycle -> exception wins; o_busy=1 for 2 cycles; o_mcauseWr=i_exCause.
REQ-036 i_rst asserted during TRAP_SAVE -> o_csrWe=0 and o_pc=RESET_PC at once; normal fetch resumes after release.
REQ-037 o_pc=0xFFFF_FFFC, no redirect -> next o_pc=0x0000_0000.
